// File: rtl/uart_tx_sequencer_pkg.sv
// Shared definitions for the UART transmit sequencer: FSM encodings,
// frame counter width and the shared timer width helper.
package uart_tx_sequencer_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_GAP       = 3'd6
    } state_t;

    // One timer serves both the busy timeout and the inter-frame gap.
    function automatic int timer_width(input int timeout_cycles, input int gap_cycles);
        int max_v;
        max_v = 2;
        if (timeout_cycles > max_v) begin
            max_v = timeout_cycles;
        end else begin
            max_v = max_v;
        end
        if (gap_cycles > max_v) begin
            max_v = gap_cycles;
        end else begin
            max_v = max_v;
        end
        return $clog2(max_v);
    endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// Pops words from the TX circular buffer and hands them to the UART
// serializer one frame at a time, with busy timeout and optional gap.
module uart_tx_sequencer
    import uart_tx_sequencer_pkg::*;
#(
    parameter int BIT_PER_WORD   = 7,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_enable,
    input  logic                   fifo_empty,
    input  logic [BIT_PER_WORD:0]  fifo_data,
    output logic                   fifo_rd_en,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [BIT_PER_WORD:0]  tx_data,
    output logic                   active,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   err_timeout,
    input  logic                   err_clr
);

    localparam int TW = timer_width(TIMEOUT_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD     = TW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t                   state_r;
    state_t                   state_next_s;
    logic [TW-1:0]            timer_r;
    logic [TW-1:0]            timer_next_s;
    logic                     capture_s;
    logic                     frame_done_s;
    logic                     err_set_s;
    logic [BIT_PER_WORD:0]    tx_data_r;
    logic [FRAME_CNT_W-1:0]   frame_count_r;
    logic                     err_timeout_r;
    logic                     rd_en_s;
    logic                     start_s;
    logic                     active_s;

    // State and shared timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= '0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
        end
    end

    // Next-state, timer and datapath-strobe decode.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        capture_s    = 1'b0;
        frame_done_s = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tx_enable && !fifo_empty && !tx_busy) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_next_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture_s    = 1'b1;
                state_next_s = ST_START;
            end
            ST_START: begin
                timer_next_s = TIMEOUT_LOAD;
                state_next_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next_s = ST_WAIT_DONE;
                end else if (timer_r == '0) begin
                    err_set_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    timer_next_s = timer_r - TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    frame_done_s = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        timer_next_s = GAP_LOAD;
                        state_next_s = ST_GAP;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (timer_r == '0) begin
                    state_next_s = ST_IDLE;
                end else begin
                    timer_next_s = timer_r - TW'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                timer_next_s = '0;
            end
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        rd_en_s  = 1'b0;
        start_s  = 1'b0;
        active_s = 1'b1;
        case (state_r)
            ST_IDLE:  active_s = 1'b0;
            ST_READ:  rd_en_s  = 1'b1;
            ST_START: start_s  = 1'b1;
            default:  active_s = 1'b1;
        endcase
    end

    // Word hand-off register: held from START until the next CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_r <= '0;
        end else if (capture_s) begin
            tx_data_r <= fifo_data;
        end else begin
            tx_data_r <= tx_data_r;
        end
    end

    // Completed-frame counter; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_r <= '0;
        end else if (frame_done_s) begin
            frame_count_r <= frame_count_r + 16'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    // Sticky timeout flag; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout_r <= 1'b0;
        end else if (err_set_s) begin
            err_timeout_r <= 1'b1;
        end else if (err_clr) begin
            err_timeout_r <= 1'b0;
        end else begin
            err_timeout_r <= err_timeout_r;
        end
    end

    assign fifo_rd_en  = rd_en_s;
    assign tx_start    = start_s;
    assign active      = active_s;
    assign tx_data     = tx_data_r;
    assign frame_count = frame_count_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a buffer model and a
// transmitter model; table of single frames plus hand-written corner cases.
module tb_uart_tx_sequencer;

    localparam int GAP = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_enable;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        active;
    logic [15:0] frame_count;
    logic        err_timeout;
    logic        err_clr;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:63];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  rd_count = 0;
    bit  underflow = 1'b0;
    int  busy_cnt = 0;
    int  busy_len = 10;
    bit  tx_stuck = 1'b0;
    bit  force_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_sequencer #(
        .BIT_PER_WORD  (7),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_enable  (tx_enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .active     (active),
        .frame_count(frame_count),
        .err_timeout(err_timeout),
        .err_clr    (err_clr)
    );

    // Buffer model with one-cycle registered read data.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_count <= rd_count + 1;
            if (wr_ptr == rd_ptr) begin
                underflow <= 1'b1;
            end else begin
                fifo_data <= mem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // Transmitter model: busy for busy_len cycles starting the cycle after tx_start.
    assign tx_busy = force_busy || (busy_cnt != 0);
    always @(posedge clk) begin
        if (tx_start && !tx_stuck) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    typedef struct {
        logic [7:0]  word;
        int          blen;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 200 && !tx_start; i++) tick();
        check("tx_start seen", {31'd0, tx_start}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && active; i++) tick();
        check("returned to idle", {31'd0, active}, 32'd0);
    endtask

    initial begin
        int rd_snap;
        int cnt;

        vecs[0] = '{8'hA5, 10, 16'd1};
        vecs[1] = '{8'h3C, 3,  16'd2};
        vecs[2] = '{8'hFF, 1,  16'd3};
        vecs[3] = '{8'h00, 6,  16'd4};

        rst_n = 1'b0; tx_enable = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check("reset rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("reset tx_start", {31'd0, tx_start}, 32'd0);
        check("reset tx_data", {24'd0, tx_data}, 32'd0);
        check("reset active", {31'd0, active}, 32'd0);
        check("reset frame_count", {16'd0, frame_count}, 32'd0);
        check("reset err_timeout", {31'd0, err_timeout}, 32'd0);
        rst_n = 1'b1;
        tx_enable = 1'b1;
        tick();

        // Single frames: pop latency, start latency, data, count.
        for (int v = 0; v < 4; v++) begin
            busy_len = vecs[v].blen;
            push(vecs[v].word);
            tick();
            check("pop latency", {31'd0, fifo_rd_en}, 32'd1);
            tick();
            check("rd_en single pulse", {31'd0, fifo_rd_en}, 32'd0);
            tick();
            check("start latency", {31'd0, tx_start}, 32'd1);
            check("tx_data at start", {24'd0, tx_data}, {24'd0, vecs[v].word});
            tick();
            check("start single pulse", {31'd0, tx_start}, 32'd0);
            wait_idle();
            check("frame_count", {16'd0, frame_count}, {16'd0, vecs[v].exp_count});
            check("buffer empty after", {31'd0, fifo_empty}, 32'd1);
        end

        // Burst of three with gap: order and busy-fall to next pop spacing.
        busy_len = 5;
        push(8'h01); push(8'h02); push(8'h03);
        for (int f = 0; f < 3; f++) begin
            wait_start();
            check("burst data", {24'd0, tx_data}, {24'd0, 8'(f + 1)});
            for (int i = 0; i < 50 && !tx_busy; i++) tick();
            for (int i = 0; i < 50 && tx_busy; i++) tick();
            if (f < 2) begin
                cnt = 0;
                while (!fifo_rd_en && cnt < 50) begin
                    tick();
                    cnt++;
                end
                check("busy fall to pop", cnt, GAP + 2);
            end
        end
        wait_idle();
        check("burst frame_count", {16'd0, frame_count}, 32'd7);

        // Enable drop during the second of three frames.
        rd_snap = rd_count;
        push(8'h11); push(8'h22); push(8'h33);
        wait_start();
        tick();
        wait_start();
        tx_enable = 1'b0;
        wait_idle();
        repeat (12) tick();
        check("enable drop pops", rd_count - rd_snap, 32'd2);
        check("enable drop count", {16'd0, frame_count}, 32'd9);
        check("enable drop left", wr_ptr - rd_ptr, 32'd1);
        tx_enable = 1'b1;
        wait_start();
        check("leftover word", {24'd0, tx_data}, 32'h33);
        wait_idle();

        // Timeout: transmitter never goes busy.
        tx_stuck = 1'b1;
        push(8'h77);
        wait_start();
        repeat (TMO) tick();
        check("timeout not early", {31'd0, err_timeout}, 32'd0);
        tick();
        check("timeout at T+1", {31'd0, err_timeout}, 32'd1);
        check("idle after timeout", {31'd0, active}, 32'd0);
        check("timeout count held", {16'd0, frame_count}, 32'd10);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("err_clr clears", {31'd0, err_timeout}, 32'd0);
        push(8'h78);
        wait_start();
        repeat (TMO) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("set beats clear", {31'd0, err_timeout}, 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("err_clr again", {31'd0, err_timeout}, 32'd0);
        tx_stuck = 1'b0;

        // Reset during WAIT_DONE.
        busy_len = 20;
        push(8'h5A); push(8'h6B);
        wait_start();
        repeat (3) tick();
        check("mid frame active", {31'd0, active}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async rst active", {31'd0, active}, 32'd0);
        check("async rst count", {16'd0, frame_count}, 32'd0);
        check("async rst data", {24'd0, tx_data}, 32'd0);
        check("async rst rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("async rst start", {31'd0, tx_start}, 32'd0);
        check("async rst err", {31'd0, err_timeout}, 32'd0);
        for (int i = 0; i < 50 && tx_busy; i++) tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("pop after reset", {31'd0, fifo_rd_en}, 32'd1);
        wait_start();
        check("data after reset", {24'd0, tx_data}, 32'h6B);
        wait_idle();
        check("count after reset", {16'd0, frame_count}, 32'd1);

        // Busy at entry holds off the pop.
        busy_len = 5;
        force_busy = 1'b1;
        rd_snap = rd_count;
        push(8'h99);
        repeat (8) tick();
        check("no pop while busy", rd_count - rd_snap, 32'd0);
        check("idle while busy", {31'd0, active}, 32'd0);
        force_busy = 1'b0;
        tick();
        check("pop after busy", {31'd0, fifo_rd_en}, 32'd1);
        wait_start();
        check("busy entry data", {24'd0, tx_data}, 32'h99);
        wait_idle();
        check("busy entry count", {16'd0, frame_count}, 32'd2);
        check("no underflow", {31'd0, underflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
